// File: rtl/uart_pkg.sv
// Constants and helpers shared by the UART receiver, transmitter and RX buffer.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive strobe plus FIFO-head valid/ready handshake of the UART RX buffer.
interface uart_rx_fifo_if #(
    parameter int unsigned p_WORD_LEN = 8
) ();

    logic [p_WORD_LEN:0]   i_data;
    logic                  i_dv;
    logic [p_WORD_LEN-1:0] o_data;
    logic                  o_perr_tag;
    logic                  o_valid;
    logic                  i_ready;

    modport slave (
        input  i_data, i_dv, i_ready,
        output o_data, o_perr_tag, o_valid
    );

    modport master (
        output i_data, i_dv, i_ready,
        input  o_data, o_perr_tag, o_valid
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the RX FIFO: synchronous write, asynchronous read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned p_WIDTH = 9,
    parameter int unsigned p_DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [clog2(p_DEPTH)-1:0]  i_waddr,
    input  logic [p_WIDTH-1:0]         i_wdata,
    input  logic [clog2(p_DEPTH)-1:0]  i_raddr,
    output logic [p_WIDTH-1:0]         o_rdata
);

    logic [p_WIDTH-1:0] mem_q [p_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: parity check, first-word-fall-through FIFO with
// valid/ready head, occupancy count and sticky overflow/parity flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned p_WORD_LEN = 8,
    parameter int unsigned p_PARITY   = PAR_EVEN,
    parameter int unsigned p_DROP_BAD = 0,
    parameter int unsigned p_DEPTH    = 16,
    parameter int unsigned p_AF_LEVEL = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    uart_rx_fifo_if.slave              bus,
    output logic [clog2(p_DEPTH):0]    o_count,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    output logic                       o_parity_err,
    input  logic                       i_clr_err
);

    localparam int unsigned AW = clog2(p_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [AW:0] AF_LVL = PW'(p_AF_LEVEL);

    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic                  af_q, af_d, ovf_q, ovf_d, perr_q, perr_d;
    logic [p_WORD_LEN-1:0] hold_q, hold_d;
    logic [p_WORD_LEN:0]   rd_word, wr_word;
    logic                  bad, push_req, push, pop, full, empty;

    always_comb begin
        bad = 1'b0;
        if (p_PARITY != PAR_NONE) begin
            bad = (^bus.i_data) ^ (p_PARITY == PAR_ODD);
        end
        push_req = bus.i_dv & ~(bad & (p_DROP_BAD != 0));
        empty    = (wptr_q == rptr_q);
        full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop      = ~empty & bus.i_ready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push     = push_req & (~full | pop);
        wr_word  = {bad & (p_DROP_BAD == 0), bus.i_data[p_WORD_LEN-1:0]};

        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        af_d   = (count_d >= AF_LVL);
        ovf_d  = (push_req & full & ~pop) | (ovf_q & ~i_clr_err);
        perr_d = (bus.i_dv & bad) | (perr_q & ~i_clr_err);
        // Last popped payload is kept so o_data holds while the FIFO is empty.
        hold_d = pop ? rd_word[p_WORD_LEN-1:0] : hold_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            hold_q  <= hold_d;
        end
    end

    uart_fifo_mem #(
        .p_WIDTH (p_WORD_LEN + 1),
        .p_DEPTH (p_DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wptr_q[AW-1:0]),
        .i_wdata (wr_word),
        .i_raddr (rptr_q[AW-1:0]),
        .o_rdata (rd_word)
    );

    assign bus.o_valid    = ~empty;
    assign bus.o_data     = empty ? hold_q : rd_word[p_WORD_LEN-1:0];
    assign bus.o_perr_tag = ~empty & rd_word[p_WORD_LEN];
    assign o_count        = count_q;
    assign o_almost_full  = af_q;
    assign o_overflow     = ovf_q;
    assign o_parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a store-bad instance and a drop-bad instance.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       clr, clr_d;
    logic [4:0] cnt, cnt_d;
    logic       af, af_d, ovf, ovf_d, perr, perr_d;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_rx_fifo_if #(.p_WORD_LEN(8)) ifm ();
    uart_rx_fifo_if #(.p_WORD_LEN(8)) ifd ();

    uart_rx_fifo #(
        .p_WORD_LEN (8), .p_PARITY (1), .p_DROP_BAD (0), .p_DEPTH (16), .p_AF_LEVEL (12)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n), .bus (ifm.slave), .o_count (cnt),
        .o_almost_full (af), .o_overflow (ovf), .o_parity_err (perr), .i_clr_err (clr)
    );

    uart_rx_fifo #(
        .p_WORD_LEN (8), .p_PARITY (1), .p_DROP_BAD (1), .p_DEPTH (16), .p_AF_LEVEL (12)
    ) dut_drop (
        .i_clk (clk), .i_rst_n (rst_n), .bus (ifd.slave), .o_count (cnt_d),
        .o_almost_full (af_d), .o_overflow (ovf_d), .o_parity_err (perr_d), .i_clr_err (clr_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [8:0]  data;
        logic        dv, rdy, clr;
        logic        valid;
        logic [7:0]  odata;
        logic        tag;
        int unsigned cnt;
        logic        af, ovf, perr;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [8:0] d, input logic dv, input logic rdy, input logic c);
        ifm.i_data  = d;
        ifm.i_dv    = dv;
        ifm.i_ready = rdy;
        clr         = c;
        step();
        ifm.i_dv    = 1'b0;
        ifm.i_ready = 1'b0;
        clr         = 1'b0;
    endtask

    task automatic apply_drop(input logic [8:0] d);
        ifd.i_data = d;
        ifd.i_dv   = 1'b1;
        step();
        ifd.i_dv   = 1'b0;
    endtask

    function automatic logic [8:0] even_word(input logic [7:0] b);
        return {^b, b};
    endfunction

    initial begin
        rst_n = 1'b0;
        ifm.i_data = '0; ifm.i_dv = 1'b0; ifm.i_ready = 1'b0; clr = 1'b0;
        ifd.i_data = '0; ifd.i_dv = 1'b0; ifd.i_ready = 1'b0; clr_d = 1'b0;

        vt[0]  = '{9'h0A5, 1, 0, 0, 1, 8'hA5, 0, 1, 0, 0, 0};
        vt[1]  = '{9'h1A5, 1, 0, 0, 1, 8'hA5, 0, 2, 0, 0, 1};
        vt[2]  = '{9'h000, 0, 1, 0, 1, 8'hA5, 1, 1, 0, 0, 1};
        vt[3]  = '{9'h000, 0, 1, 0, 0, 8'hA5, 0, 0, 0, 0, 1};
        vt[4]  = '{9'h13C, 1, 0, 1, 1, 8'h3C, 1, 1, 0, 0, 1};
        vt[5]  = '{9'h000, 0, 0, 1, 1, 8'h3C, 1, 1, 0, 0, 0};
        vt[6]  = '{9'h101, 1, 1, 0, 1, 8'h01, 0, 1, 0, 0, 0};
        vt[7]  = '{9'h000, 0, 1, 0, 0, 8'h01, 0, 0, 0, 0, 0};
        vt[8]  = '{9'h000, 0, 1, 0, 0, 8'h01, 0, 0, 0, 0, 0};
        vt[9]  = '{9'h007, 1, 1, 0, 1, 8'h07, 1, 1, 0, 0, 1};
        vt[10] = '{9'h000, 0, 1, 0, 0, 8'h07, 0, 0, 0, 0, 1};
        vt[11] = '{9'h000, 0, 0, 1, 0, 8'h07, 0, 0, 0, 0, 0};

        #1;
        chk("rst_valid", ifm.o_valid, 0);
        chk("rst_data", ifm.o_data, 0);
        chk("rst_tag", ifm.o_perr_tag, 0);
        chk("rst_count", cnt, 0);
        chk("rst_af", af, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_perr", perr, 0);
        step();
        step();
        rst_n = 1'b1;

        // Drop-bad instance: good A5 kept, bad A5 discarded but flagged.
        apply_drop(9'h0A5);
        apply_drop(9'h1A5);
        chk("drop_count", cnt_d, 1);
        chk("drop_valid", ifd.o_valid, 1);
        chk("drop_data", ifd.o_data, 8'hA5);
        chk("drop_tag", ifd.o_perr_tag, 0);
        chk("drop_perr", perr_d, 1);
        chk("drop_ovf", ovf_d, 0);

        for (int i = 0; i < 12; i++) begin
            apply(vt[i].data, vt[i].dv, vt[i].rdy, vt[i].clr);
            chk($sformatf("v%0d_valid", i), ifm.o_valid, vt[i].valid);
            chk($sformatf("v%0d_data", i), ifm.o_data, vt[i].odata);
            chk($sformatf("v%0d_tag", i), ifm.o_perr_tag, vt[i].tag);
            chk($sformatf("v%0d_count", i), cnt, vt[i].cnt);
            chk($sformatf("v%0d_af", i), af, vt[i].af);
            chk($sformatf("v%0d_ovf", i), ovf, vt[i].ovf);
            chk($sformatf("v%0d_perr", i), perr, vt[i].perr);
        end

        // Fill to full with 00..0F, then one word too many.
        for (int i = 0; i < 16; i++) begin
            apply(even_word(8'(i)), 1, 0, 0);
            chk($sformatf("fill%0d_count", i), cnt, i + 1);
            chk($sformatf("fill%0d_af", i), af, (i + 1 >= 12) ? 1 : 0);
        end
        apply(9'h055, 1, 0, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", cnt, 16);
        chk("ovf_head", ifm.o_data, 8'h00);

        apply(9'h000, 0, 0, 1);
        chk("ovf_clr", ovf, 0);

        // Full with simultaneous push and pop: no overflow, count holds.
        apply(9'h0AA, 1, 1, 0);
        chk("fullpp_count", cnt, 16);
        chk("fullpp_ovf", ovf, 0);
        chk("fullpp_af", af, 1);

        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), ifm.o_valid, 1);
            chk($sformatf("drain%0d_data", i), ifm.o_data, i);
            apply(9'h000, 0, 1, 0);
        end
        chk("drain_last_data", ifm.o_data, 8'hAA);
        chk("drain_last_count", cnt, 1);
        chk("drain_af", af, 0);
        apply(9'h000, 0, 1, 0);
        chk("drain_empty_valid", ifm.o_valid, 0);
        chk("drain_empty_count", cnt, 0);

        // Asynchronous reset with five words held.
        for (int i = 0; i < 5; i++) begin
            apply(even_word(8'(8'h10 + i)), 1, 0, 0);
        end
        chk("pre_rst_count", cnt, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ifm.o_valid, 0);
        chk("async_rst_count", cnt, 0);
        chk("async_rst_data", ifm.o_data, 0);
        chk("async_rst_drop_count", cnt_d, 0);
        chk("async_rst_drop_perr", perr_d, 0);
        step();
        rst_n = 1'b1;
        apply(9'h05A, 1, 0, 0);
        chk("post_rst_valid", ifm.o_valid, 1);
        chk("post_rst_data", ifm.o_data, 8'h5A);
        chk("post_rst_count", cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
